intra_loop: RTL and testbench

Per-block intra prediction and reconstruction engine for the intra encoder, used as the DUT `intraloop`. Three independent channels run in parallel: luma 4x4, chroma-blue 8x8 and chroma-red 8x8. For each block, a channel predicts from the already-reconstructed neighbour pixels, forms and (optionally) quantizes the residual, and returns the reconstructed block. It pulses a per-channel feedback strobe, which the encoder top uses to write the block back into its frame buffers and to advance that channel's block address.

---
 rtl/intra_loop_pkg.sv | 38 +++
 rtl/intra_loop_pred_unit.sv | 206 ++++++++++++++++++++
 rtl/intra_loop.sv | 97 +++++++++
 tb/tb_intra_loop.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intra_loop_pkg.sv
// -----------------------------------------------------------------------------
// intraloop_pkg
// Shared types and helpers for the intra prediction / reconstruction engine.
//   mode_e     : chosen prediction mode (DC, vertical, horizontal)
//   state_e    : per-channel block FSM states
//   clip8      : saturate a signed reconstruction sum to 0..255
//   FB_PERIOD  : cycles between feedback pulses under continuous enable
// -----------------------------------------------------------------------------
package intraloop_pkg;

  localparam int FB_PERIOD = 5;

  typedef enum logic [1:0] {
    MODE_DC = 2'd0,
    MODE_V  = 2'd1,
    MODE_H  = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_SAD      = 3'd2,
    ST_SELECT   = 3'd3,
    ST_RECON    = 3'd4,
    ST_FEEDBACK = 3'd5
  } state_e;

  function automatic logic [7:0] clip8(input logic signed [10:0] v);
    if (v < 11'sd0) begin
      return 8'd0;
    end else if (v > 11'sd255) begin
      return 8'd255;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/intra_loop_pred_unit.sv
// -----------------------------------------------------------------------------
// intra_pred_unit
// One NxN intra channel: captures neighbours and source block, evaluates the
// DC / vertical / horizontal predictors by SAD, forms the residual, optionally
// quantizes it, and presents the reconstructed block with a one-cycle strobe.
//
// Build option: INTRALOOP_QUANT_EN -- when defined the residual is quantized
// with step 2^QSHIFT (round half away from zero); otherwise reconstruction is
// lossless. FSM timing is identical in both builds.
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   enable_i         start / continue processing blocks
//   mbnumber_i       block origin, [31:16] row, [15:0] column
//   top_i, left_i    N neighbour pixels above / left of the block
//   orig_i           N*N source pixels, raster order
//   fb_o             one-cycle block-done strobe (FEEDBACK state)
//   reconst_o        reconstructed block, held until the next FEEDBACK
//   mode_o           chosen mode, held until the next FEEDBACK
//
// Handshake: no back-pressure. A block starts on any IDLE/FEEDBACK cycle with
// enable_i=1; inputs are sampled only in CAPTURE; fb_o=1 marks the single cycle
// in which reconst_o/mode_o first carry the new block's result.
// -----------------------------------------------------------------------------
module intra_pred_unit
  import intraloop_pkg::*;
#(
  parameter int N      = 4,
  parameter int QSHIFT = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [31:0]          mbnumber_i,
  input  logic [N-1:0][7:0]    top_i,
  input  logic [N-1:0][7:0]    left_i,
  input  logic [N*N-1:0][7:0]  orig_i,
  output logic                 fb_o,
  output logic [N*N-1:0][7:0]  reconst_o,
  output logic [1:0]           mode_o
);

  localparam int NN    = N * N;
  localparam int LOG2N = $clog2(N);

  state_e state_q, state_d;

  logic                top_av_q, left_av_q;
  logic [N-1:0][7:0]   top_q, left_q;
  logic [NN-1:0][7:0]  orig_q;

  logic [11:0]         sum_top, sum_left;
  logic [7:0]          dc_d, dc_q;
  logic [13:0]         sad_dc_d, sad_v_d, sad_h_d;
  logic [13:0]         sad_dc_q, sad_v_q, sad_h_q;
  logic [13:0]         best_sad;
  mode_e               mode_sel_d, mode_sel_q, mode_q;
  logic [NN-1:0][7:0]  pred_d, pred_q;
  logic [NN-1:0][7:0]  recon_d, reconst_q;

  logic signed [8:0]   resid;
  logic signed [10:0]  rq, recon_sum;
`ifdef INTRALOOP_QUANT_EN
  logic [10:0]         mag, qmag;
`endif

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    fb_o    = 1'b0;
    case (state_q)
      ST_IDLE:     if (enable_i) state_d = ST_CAPTURE;
      ST_CAPTURE:  state_d = ST_SAD;
      ST_SAD:      state_d = ST_SELECT;
      ST_SELECT:   state_d = ST_RECON;
      ST_RECON:    state_d = ST_FEEDBACK;
      ST_FEEDBACK: begin
        fb_o    = 1'b1;
        state_d = enable_i ? ST_CAPTURE : ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // ---------------- DC predictor and SADs (from captured data) ----------------
  always_comb begin
    sum_top  = '0;
    sum_left = '0;
    for (int k = 0; k < N; k++) begin
      sum_top  = sum_top  + {4'd0, top_q[k]};
      sum_left = sum_left + {4'd0, left_q[k]};
    end
    dc_d = 8'd128;
    if (top_av_q && left_av_q) begin
      dc_d = 8'((sum_top + sum_left + 12'(N)) >> (LOG2N + 1));
    end else if (top_av_q) begin
      dc_d = 8'((sum_top + 12'(N / 2)) >> LOG2N);
    end else if (left_av_q) begin
      dc_d = 8'((sum_left + 12'(N / 2)) >> LOG2N);
    end

    // V/H SADs are always computed; availability gates them at selection.
    sad_dc_d = '0;
    sad_v_d  = '0;
    sad_h_d  = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sad_dc_d = sad_dc_d + {6'd0, absdiff(orig_q[i*N+j], dc_d)};
        sad_v_d  = sad_v_d  + {6'd0, absdiff(orig_q[i*N+j], top_q[j])};
        sad_h_d  = sad_h_d  + {6'd0, absdiff(orig_q[i*N+j], left_q[i])};
      end
    end
  end

  // ---------------- mode selection; strict '<' keeps ties on DC, then V ----------------
  always_comb begin
    mode_sel_d = MODE_DC;
    best_sad   = sad_dc_q;
    if (top_av_q && (sad_v_q < best_sad)) begin
      mode_sel_d = MODE_V;
      best_sad   = sad_v_q;
    end
    if (left_av_q && (sad_h_q < best_sad)) begin
      mode_sel_d = MODE_H;
    end
    pred_d = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (mode_sel_d)
          MODE_V:  pred_d[i*N+j] = top_q[j];
          MODE_H:  pred_d[i*N+j] = left_q[i];
          default: pred_d[i*N+j] = dc_q;
        endcase
      end
    end
  end

  // ---------------- residual, quantization, reconstruction ----------------
  always_comb begin
    recon_d   = '0;
    resid     = '0;
    rq        = '0;
    recon_sum = '0;
`ifdef INTRALOOP_QUANT_EN
    mag       = '0;
    qmag      = '0;
`endif
    for (int k = 0; k < NN; k++) begin
      resid = $signed({1'b0, orig_q[k]}) - $signed({1'b0, pred_q[k]});
`ifdef INTRALOOP_QUANT_EN
      // Quantize the magnitude, then restore the sign: round half away from zero.
      mag  = resid[8] ? 11'(-resid) : 11'(resid);
      qmag = (mag + 11'(1 << (QSHIFT - 1))) >> QSHIFT;
      rq   = resid[8] ? -$signed(qmag << QSHIFT) : $signed(qmag << QSHIFT);
`else
      rq   = 11'(resid);
`endif
      recon_sum  = $signed({3'b000, pred_q[k]}) + rq;
      recon_d[k] = clip8(recon_sum);
    end
  end

  // ---------------- control and output registers ----------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      reconst_q <= '0;
      mode_q    <= MODE_DC;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RECON) begin
        reconst_q <= recon_d;
        mode_q    <= mode_sel_q;
      end
    end
  end

  // ---------------- datapath pipeline registers (one stage per FSM state) ----------------
  always_ff @(posedge clk_i) begin
    if (state_q == ST_CAPTURE) begin
      top_av_q  <= (mbnumber_i[31:16] != 16'd0);
      left_av_q <= (mbnumber_i[15:0]  != 16'd0);
      top_q     <= top_i;
      left_q    <= left_i;
      orig_q    <= orig_i;
    end
    if (state_q == ST_SAD) begin
      dc_q     <= dc_d;
      sad_dc_q <= sad_dc_d;
      sad_v_q  <= sad_v_d;
      sad_h_q  <= sad_h_d;
    end
    if (state_q == ST_SELECT) begin
      mode_sel_q <= mode_sel_d;
      pred_q     <= pred_d;
    end
  end

  assign reconst_o = reconst_q;
  assign mode_o    = mode_q;

endmodule

// File: rtl/intra_loop.sv
// -----------------------------------------------------------------------------
// intra_loop
// Intra prediction and reconstruction engine: three independent channels
// (luma 4x4, chroma-blue 8x8, chroma-red 8x8), each an intra_pred_unit.
//
// Build option: INTRALOOP_QUANT_EN enables residual quantization (step
// 2^QSHIFT); undefined gives lossless reconstruction.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   enable                          run all three channels
//   mbnumber_*                      block origin per channel ([31:16] row, [15:0] col)
//   top_*/left_*                    neighbour pixels per channel
//   orig_*                          source block per channel, raster order
//   fb_*                            one-cycle block-done strobe per channel
//   reconst_*                       reconstructed block per channel
//   mode_*                          chosen mode per channel (0 DC, 1 V, 2 H)
// -----------------------------------------------------------------------------
module intra_loop #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  parameter int QSHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [31:0]       mbnumber_luma4x4,
  input  logic [31:0]       mbnumber_chromab8x8,
  input  logic [31:0]       mbnumber_chromar8x8,
  input  logic [3:0][7:0]   top_luma,
  input  logic [3:0][7:0]   left_luma,
  input  logic [7:0][7:0]   top_chb,
  input  logic [7:0][7:0]   left_chb,
  input  logic [7:0][7:0]   top_chr,
  input  logic [7:0][7:0]   left_chr,
  input  logic [15:0][7:0]  orig_luma4x4,
  input  logic [63:0][7:0]  orig_chromab8x8,
  input  logic [63:0][7:0]  orig_chromar8x8,
  output logic              fb_luma4x4,
  output logic              fb_chromab8x8,
  output logic              fb_chromar8x8,
  output logic [15:0][7:0]  reconst_luma4x4,
  output logic [63:0][7:0]  reconst_chromab8x8,
  output logic [63:0][7:0]  reconst_chromar8x8,
  output logic [1:0]        mode_luma,
  output logic [1:0]        mode_chb,
  output logic [1:0]        mode_chr
);

  // Frame size is informational only; reject nonsensical configurations.
  if (QSHIFT < 1 || QSHIFT > 6) begin : g_bad_qshift
    $error("intra_loop: QSHIFT must be in 1..6");
  end
  if (WIDTH < 1 || HEIGHT < 1) begin : g_bad_frame
    $error("intra_loop: WIDTH and HEIGHT must be positive");
  end

  intra_pred_unit #(.N(4), .QSHIFT(QSHIFT)) u_luma (
    .clk_i      (clk),
    .reset_i    (reset),
    .enable_i   (enable),
    .mbnumber_i (mbnumber_luma4x4),
    .top_i      (top_luma),
    .left_i     (left_luma),
    .orig_i     (orig_luma4x4),
    .fb_o       (fb_luma4x4),
    .reconst_o  (reconst_luma4x4),
    .mode_o     (mode_luma)
  );

  intra_pred_unit #(.N(8), .QSHIFT(QSHIFT)) u_chb (
    .clk_i      (clk),
    .reset_i    (reset),
    .enable_i   (enable),
    .mbnumber_i (mbnumber_chromab8x8),
    .top_i      (top_chb),
    .left_i     (left_chb),
    .orig_i     (orig_chromab8x8),
    .fb_o       (fb_chromab8x8),
    .reconst_o  (reconst_chromab8x8),
    .mode_o     (mode_chb)
  );

  intra_pred_unit #(.N(8), .QSHIFT(QSHIFT)) u_chr (
    .clk_i      (clk),
    .reset_i    (reset),
    .enable_i   (enable),
    .mbnumber_i (mbnumber_chromar8x8),
    .top_i      (top_chr),
    .left_i     (left_chr),
    .orig_i     (orig_chromar8x8),
    .fb_o       (fb_chromar8x8),
    .reconst_o  (reconst_chromar8x8),
    .mode_o     (mode_chr)
  );

endmodule

// File: tb/tb_intra_loop.sv
// -----------------------------------------------------------------------------
// tb_intra_loop
// Self-checking bench for intra_loop. Expected blocks come from a pixel-level
// reference model of the prediction / mode-choice / reconstruction rules.
// -----------------------------------------------------------------------------
module tb_intra_loop;

  localparam int QS     = 2;
  localparam int FB_GAP = 5;
  localparam int W      = 1158;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [31:0]       mbnumber_luma4x4, mbnumber_chromab8x8, mbnumber_chromar8x8;
  logic [3:0][7:0]   top_luma, left_luma;
  logic [7:0][7:0]   top_chb, left_chb, top_chr, left_chr;
  logic [15:0][7:0]  orig_luma4x4;
  logic [63:0][7:0]  orig_chromab8x8, orig_chromar8x8;
  logic              fb_luma4x4, fb_chromab8x8, fb_chromar8x8;
  logic [15:0][7:0]  reconst_luma4x4;
  logic [63:0][7:0]  reconst_chromab8x8, reconst_chromar8x8;
  logic [1:0]        mode_luma, mode_chb, mode_chr;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  intra_loop #(.WIDTH(1280), .HEIGHT(720), .QSHIFT(QS)) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .mbnumber_luma4x4    (mbnumber_luma4x4),
    .mbnumber_chromab8x8 (mbnumber_chromab8x8),
    .mbnumber_chromar8x8 (mbnumber_chromar8x8),
    .top_luma            (top_luma),
    .left_luma           (left_luma),
    .top_chb             (top_chb),
    .left_chb            (left_chb),
    .top_chr             (top_chr),
    .left_chr            (left_chr),
    .orig_luma4x4        (orig_luma4x4),
    .orig_chromab8x8     (orig_chromab8x8),
    .orig_chromar8x8     (orig_chromar8x8),
    .fb_luma4x4          (fb_luma4x4),
    .fb_chromab8x8       (fb_chromab8x8),
    .fb_chromar8x8       (fb_chromar8x8),
    .reconst_luma4x4     (reconst_luma4x4),
    .reconst_chromab8x8  (reconst_chromab8x8),
    .reconst_chromar8x8  (reconst_chromar8x8),
    .mode_luma           (mode_luma),
    .mode_chb            (mode_chb),
    .mode_chr            (mode_chr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model(input int n, input logic [31:0] mb,
                                input logic [63:0] top, input logic [63:0] left,
                                input logic [511:0] orig,
                                output logic [511:0] rec, output logic [1:0] mode);
    int st, sl, dc, best, p, o, d, v, q;
    int sad [3];
    bit tav, lav;
    tav = (mb[31:16] != 16'd0);
    lav = (mb[15:0] != 16'd0);
    st = 0;
    sl = 0;
    for (int k = 0; k < n; k++) begin
      st += int'(top[k*8 +: 8]);
      sl += int'(left[k*8 +: 8]);
    end
    if (tav && lav)  dc = (st + sl + n) / (2 * n);
    else if (tav)    dc = (st + n / 2) / n;
    else if (lav)    dc = (sl + n / 2) / n;
    else             dc = 128;
    for (int m = 0; m < 3; m++) begin
      sad[m] = 0;
      for (int i = 0; i < n; i++) begin
        for (int j = 0; j < n; j++) begin
          p = (m == 0) ? dc : (m == 1) ? int'(top[j*8 +: 8]) : int'(left[i*8 +: 8]);
          d = int'(orig[(i*n+j)*8 +: 8]) - p;
          sad[m] += (d < 0) ? -d : d;
        end
      end
    end
    best = 0;
    if (tav && sad[1] < sad[best]) best = 1;
    if (lav && sad[2] < sad[best]) best = 2;
    rec = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        p = (best == 0) ? dc : (best == 1) ? int'(top[j*8 +: 8]) : int'(left[i*8 +: 8]);
        o = int'(orig[(i*n+j)*8 +: 8]);
        d = o - p;
`ifdef INTRALOOP_QUANT_EN
        q = (((d < 0) ? -d : d) + (1 << (QS - 1))) / (1 << QS);
        if (d < 0) q = -q;
        v = p + q * (1 << QS);
`else
        q = d;
        v = p + q;
`endif
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        rec[(i*n+j)*8 +: 8] = 8'(v);
      end
    end
    mode = 2'(best);
  endfunction

  function automatic logic [W-1:0] expect_all();
    logic [511:0] rl, rb, rr;
    logic [1:0] ml, mb, mr;
    model(4, mbnumber_luma4x4, {32'd0, top_luma}, {32'd0, left_luma}, {384'd0, orig_luma4x4}, rl, ml);
    model(8, mbnumber_chromab8x8, top_chb, left_chb, orig_chromab8x8, rb, mb);
    model(8, mbnumber_chromar8x8, top_chr, left_chr, orig_chromar8x8, rr, mr);
    return {ml, rl[127:0], mb, rb, mr, rr};
  endfunction

  function automatic logic [W-1:0] observed();
    return {mode_luma, reconst_luma4x4, mode_chb, reconst_chromab8x8, mode_chr, reconst_chromar8x8};
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rand_mb();
    logic [15:0] row, col;
    row = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 719));
    col = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 1279));
    return {row, col};
  endfunction

  function automatic logic [511:0] gen_orig(input int n, input logic [63:0] top,
                                            input logic [63:0] left, input int kind);
    logic [511:0] o;
    int v, flat;
    o = '0;
    flat = int'($urandom_range(0, 255));
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        case (kind)
          1:       v = int'(top[j*8 +: 8]) + int'($urandom_range(0, 2));
          2:       v = int'(left[i*8 +: 8]) + int'($urandom_range(0, 2));
          3:       v = flat;
          default: v = int'($urandom_range(0, 255));
        endcase
        if (v > 255) v = 255;
        o[(i*n+j)*8 +: 8] = 8'(v);
      end
    end
    return o;
  endfunction

  task automatic set_random_stim();
    logic [63:0] t, l;
    logic [511:0] o;
    t = {$urandom, $urandom};
    l = {$urandom, $urandom};
    mbnumber_luma4x4 = rand_mb();
    top_luma = t[31:0];
    left_luma = l[31:0];
    o = gen_orig(4, t, l, int'($urandom_range(0, 3)));
    orig_luma4x4 = o[127:0];
    t = {$urandom, $urandom};
    l = {$urandom, $urandom};
    mbnumber_chromab8x8 = rand_mb();
    top_chb = t;
    left_chb = l;
    orig_chromab8x8 = gen_orig(8, t, l, int'($urandom_range(0, 3)));
    t = {$urandom, $urandom};
    l = {$urandom, $urandom};
    mbnumber_chromar8x8 = rand_mb();
    top_chr = t;
    left_chr = l;
    orig_chromar8x8 = gen_orig(8, t, l, int'($urandom_range(0, 3)));
  endtask

  // All channels at the given origin with a flat source block.
  task automatic set_flat(input logic [31:0] mb, input logic [7:0] v);
    mbnumber_luma4x4 = mb;
    mbnumber_chromab8x8 = mb;
    mbnumber_chromar8x8 = mb;
    top_luma = $urandom;
    left_luma = $urandom;
    top_chb = {$urandom, $urandom};
    left_chb = {$urandom, $urandom};
    top_chr = {$urandom, $urandom};
    left_chr = {$urandom, $urandom};
    orig_luma4x4 = {16{v}};
    orig_chromab8x8 = {64{v}};
    orig_chromar8x8 = {64{v}};
  endtask

  // Pulse enable for one cycle and wait (bounded) for the luma strobe.
  // lat counts sampled cycles from the enable edge; the strobe cycle is lat.
  task automatic run_block(output bit seen, output int lat);
    seen = 1'b0;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    lat = 1;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (fb_luma4x4) seen = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int stray;
    reset = 1'b1;
    enable = 1'b0;
    set_flat(32'd0, 8'd0);
    idle_cycles(2);
    checks++;
    if ({fb_luma4x4, fb_chromab8x8, fb_chromar8x8} !== 3'b000) begin
      errors++;
      $display("FAIL reset_fb got %b exp 000", {fb_luma4x4, fb_chromab8x8, fb_chromar8x8});
    end
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero reconst/mode (modes %0d %0d %0d)", mode_luma, mode_chb, mode_chr);
    end
    reset = 1'b0;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (fb_luma4x4 || fb_chromab8x8 || fb_chromar8x8) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL idle_no_fb got %0d pulses exp 0", stray);
    end
  endtask

  task automatic test_corner_dc();
    bit seen;
    int lat;
    logic [W-1:0] e, o;
    set_flat(32'd0, 8'd100);
    e = expect_all();
    run_block(seen, lat);
    o = observed();
    checks++;
    if (!seen || lat != 5) begin
      errors++;
      $display("FAIL corner_latency got seen=%0d lat=%0d exp lat=5", seen, lat);
    end
    checks++;
    if ({fb_chromab8x8, fb_chromar8x8} !== 2'b11) begin
      errors++;
      $display("FAIL corner_chroma_fb got %b exp 11", {fb_chromab8x8, fb_chromar8x8});
    end
    checks++;
    if (mode_luma !== 2'd0 || reconst_luma4x4 !== {16{8'd100}}) begin
      errors++;
      $display("FAIL corner_luma got mode %0d pix %0d exp mode 0 pix 100", mode_luma, reconst_luma4x4[0]);
    end
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL corner_model got %h exp %h", o[W-1:1028], e[W-1:1028]);
    end
  endtask

  task automatic test_vertical();
    bit seen;
    int lat;
    logic [W-1:0] e, o;
    set_flat({16'd4, 16'd0}, 8'd0);
    top_luma = {8'd40, 8'd30, 8'd20, 8'd10};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) orig_luma4x4[i*4+j] = top_luma[j];
    mbnumber_chromab8x8 = {16'd8, 16'd0};
    mbnumber_chromar8x8 = {16'd8, 16'd0};
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        orig_chromab8x8[i*8+j] = top_chb[j];
        orig_chromar8x8[i*8+j] = top_chr[j];
      end
    e = expect_all();
    run_block(seen, lat);
    o = observed();
    checks++;
    if (!seen || {mode_luma, mode_chb, mode_chr} !== {2'd1, 2'd1, 2'd1}) begin
      errors++;
      $display("FAIL vertical_mode got seen=%0d modes %0d %0d %0d exp 1 1 1", seen, mode_luma, mode_chb, mode_chr);
    end
    checks++;
    if (reconst_luma4x4 !== orig_luma4x4) begin
      errors++;
      $display("FAIL vertical_recon got %h exp %h", reconst_luma4x4, orig_luma4x4);
    end
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL vertical_model got %h exp %h", o[1027:514], e[1027:514]);
    end
  endtask

  task automatic test_rounding_clip(input logic [7:0] src, input logic [7:0] exp_pix, input string tag);
    bit seen;
    int lat;
    logic [W-1:0] e, o;
    set_flat(32'd0, src);
    e = expect_all();
    run_block(seen, lat);
    o = observed();
    checks++;
    if (!seen || reconst_luma4x4 !== {16{exp_pix}} || reconst_chromab8x8 !== {64{exp_pix}}) begin
      errors++;
      $display("FAIL %s got seen=%0d luma %0d chb %0d exp %0d", tag, seen, reconst_luma4x4[0], reconst_chromab8x8[0], exp_pix);
    end
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s_model got %h exp %h", tag, o[W-1:1028], e[W-1:1028]);
    end
  endtask

  task automatic test_random(input int nblocks);
    bit seen;
    int lat;
    logic [W-1:0] e, o;
    for (int b = 0; b < nblocks; b++) begin
      set_random_stim();
      e = expect_all();
      enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      @(posedge clk); #1;
      // Capture is done; later input changes must not reach this block.
      set_random_stim();
      seen = 1'b0;
      lat = 2;
      while (!seen && lat < 20) begin
        @(posedge clk); #1;
        lat++;
        if (fb_luma4x4) seen = 1'b1;
      end
      o = observed();
      checks++;
      if (!seen || lat != 5) begin
        errors++;
        $display("FAIL random_latency blk %0d got seen=%0d lat=%0d exp 5", b, seen, lat);
      end
      checks++;
      if (o[W-1:1028] !== e[W-1:1028]) begin
        errors++;
        $display("FAIL random_luma blk %0d got %h exp %h", b, o[W-1:1028], e[W-1:1028]);
      end
      checks++;
      if (o[1027:514] !== e[1027:514]) begin
        errors++;
        $display("FAIL random_chb blk %0d got %h exp %h", b, o[1027:514], e[1027:514]);
      end
      checks++;
      if (o[513:0] !== e[513:0]) begin
        errors++;
        $display("FAIL random_chr blk %0d got %h exp %h", b, o[513:0], e[513:0]);
      end
      idle_cycles(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back(input int nblocks);
    int n_fb, k, last;
    logic [W-1:0] e, o;
    exp_q.delete();
    set_random_stim();
    exp_q.push_back(expect_all());
    enable = 1'b1;
    n_fb = 0;
    k = 0;
    last = -1;
    while (n_fb < nblocks && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (fb_luma4x4) begin
        o = observed();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL b2b_block %0d got %h exp %h", n_fb, o[W-1:1028], e[W-1:1028]);
        end
        if (last >= 0) begin
          checks++;
          if (k - last != FB_GAP) begin
            errors++;
            $display("FAIL b2b_interval got %0d exp %0d", k - last, FB_GAP);
          end
        end
        last = k;
        n_fb++;
        // The encoder advances the address on fb; the next capture sees it.
        if (n_fb < nblocks) begin
          set_random_stim();
          exp_q.push_back(expect_all());
        end else begin
          enable = 1'b0;
        end
      end
    end
    checks++;
    if (n_fb != nblocks || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got %0d blocks (%0d pending) exp %0d", n_fb, exp_q.size(), nblocks);
    end
    enable = 1'b0;
    idle_cycles(3);
  endtask

  task automatic test_cadence();
    int got[$];
    int want[$];
    int width_bad;
    idle_cycles(2);
    for (int p = FB_GAP - 1; p < 20; p += FB_GAP) want.push_back(p);
    width_bad = 0;
    enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (fb_luma4x4) got.push_back(k);
      if (fb_luma4x4 !== fb_chromab8x8 || fb_luma4x4 !== fb_chromar8x8) width_bad++;
      if (k == 19) enable = 1'b0;
    end
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL cadence_positions got %0d pulses (first at %0d) exp 4 at 4,9,14,19", got.size(), (got.size() > 0) ? got[0] : -1);
    end
    checks++;
    if (width_bad != 0) begin
      errors++;
      $display("FAIL cadence_channels got %0d disagreeing cycles exp 0", width_bad);
    end
  endtask

  task automatic test_enable_drop();
    int got[$];
    set_random_stim();
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (fb_luma4x4 || fb_chromab8x8 || fb_chromar8x8) got.push_back(k);
      if (k == 1) enable = 1'b0;  // channel is in SAD here
    end
    checks++;
    if (got.size() != 1 || got[0] != 4) begin
      errors++;
      $display("FAIL enable_drop got %0d pulses (first at %0d) exp 1 at 4", got.size(), (got.size() > 0) ? got[0] : -1);
    end
  endtask

  task automatic test_reset_midblock();
    int stray;
    set_random_stim();
    enable = 1'b1;
    idle_cycles(3);
    reset = 1'b1;
    idle_cycles(2);
    checks++;
    if ({fb_luma4x4, fb_chromab8x8, fb_chromar8x8} !== 3'b000 || observed() !== '0) begin
      errors++;
      $display("FAIL reset_mid got fb %b modes %0d %0d %0d exp all zero", {fb_luma4x4, fb_chromab8x8, fb_chromar8x8}, mode_luma, mode_chb, mode_chr);
    end
    reset = 1'b0;
    enable = 1'b0;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (fb_luma4x4 || fb_chromab8x8 || fb_chromar8x8) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_mid_idle got %0d pulses exp 0", stray);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    enable = 1'b0;
    set_flat(32'd0, 8'd0);
    test_reset();
    test_corner_dc();
    test_vertical();
`ifdef INTRALOOP_QUANT_EN
    test_rounding_clip(8'd130, 8'd132, "rounding");
    test_rounding_clip(8'd254, 8'd255, "clipping");
`else
    test_rounding_clip(8'd130, 8'd130, "rounding");
    test_rounding_clip(8'd254, 8'd254, "clipping");
`endif
    test_random(40);
    test_back_to_back(8);
    test_cadence();
    test_enable_drop();
    test_reset_midblock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
